// File: rtl/flags_update.sv
// ============================================================================
//  Module      : flags_update
//  Description : Registered ALU result with a staged, masked NZCV flag commit
//                that lands one edge after the result.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module flags_update (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_in,
  input  logic        hold,
  input  logic [1:0]  ALUControl,
  input  logic [31:0] SrcA,
  input  logic [31:0] SrcB,
  input  logic [1:0]  FlagW,
  input  logic        CondEx,
  output logic        ready,
  output logic        valid_out,
  output logic [31:0] Result,
  output logic [3:0]  Flags,
  output logic [3:0]  FlagsNext,
  output logic        pending
);

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  logic        valid_q, valid_d;
  logic [31:0] result_q, result_d;
  logic [3:0]  stage_q, stage_d;
  logic [1:0]  mask_q, mask_d;
  logic [3:0]  flags_q, flags_d;

  logic        is_sub;
  logic [31:0] b_eff;
  logic [32:0] alu_sum;
  logic [31:0] alu_res;
  logic        alu_c;
  logic        alu_v;
  logic [3:0]  alu_nzcv;
  logic [1:0]  op_mask;
  logic [3:0]  flags_merged;

  // SUB is folded into the adder as A + ~B + 1 so carry and overflow share logic.
  assign is_sub  = (ALUControl == ALU_SUB);
  assign b_eff   = is_sub ? ~SrcB : SrcB;
  assign alu_sum = {1'b0, SrcA} + {1'b0, b_eff} + {32'd0, is_sub};

  always_comb begin
    alu_res = alu_sum[31:0];
    alu_c   = alu_sum[32];
    alu_v   = (SrcA[31] == b_eff[31]) & (alu_sum[31] != SrcA[31]);
    op_mask = FlagW & {2{CondEx}};
    case (ALUControl)
      ALU_AND: begin
        alu_res    = SrcA & SrcB;
        alu_c      = 1'b0;
        alu_v      = 1'b0;
        op_mask[0] = 1'b0;
      end
      ALU_ORR: begin
        alu_res    = SrcA | SrcB;
        alu_c      = 1'b0;
        alu_v      = 1'b0;
        op_mask[0] = 1'b0;
      end
      default: ;
    endcase
  end

  assign alu_nzcv = {alu_res[31], (alu_res == 32'd0), alu_c, alu_v};

  assign flags_merged = {mask_q[1] ? stage_q[3:2] : flags_q[3:2],
                         mask_q[0] ? stage_q[1:0] : flags_q[1:0]};

  // Commit of the older op and capture of the newer one happen on the same edge.
  always_comb begin
    valid_d  = valid_q;
    result_d = result_q;
    stage_d  = stage_q;
    mask_d   = mask_q;
    flags_d  = flags_q;
    if (!hold) begin
      if (valid_q) begin
        flags_d = flags_merged;
      end
      valid_d = valid_in;
      if (valid_in) begin
        result_d = alu_res;
        stage_d  = alu_nzcv;
        mask_d   = op_mask;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q  <= 1'b0;
      result_q <= 32'd0;
      stage_q  <= 4'd0;
      mask_q   <= 2'd0;
      flags_q  <= 4'd0;
    end else begin
      valid_q  <= valid_d;
      result_q <= result_d;
      stage_q  <= stage_d;
      mask_q   <= mask_d;
      flags_q  <= flags_d;
    end
  end

  assign ready     = ~hold;
  assign valid_out = valid_q;
  assign Result    = result_q;
  assign Flags     = flags_q;
  assign pending   = valid_q & (mask_q != 2'd0);
  assign FlagsNext = pending ? flags_merged : flags_q;

endmodule

`default_nettype wire

// File: tb/tb_flags_update.sv
// ============================================================================
//  Module      : tb_flags_update
//  Description : Self-checking bench for flags_update against a behavioural model.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_flags_update;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_in;
  logic        hold;
  logic [1:0]  ALUControl;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic [1:0]  FlagW;
  logic        CondEx;
  logic        ready;
  logic        valid_out;
  logic [31:0] Result;
  logic [3:0]  Flags;
  logic [3:0]  FlagsNext;
  logic        pending;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  flags_update dut (
    .clk        (clk),
    .reset      (reset),
    .valid_in   (valid_in),
    .hold       (hold),
    .ALUControl (ALUControl),
    .SrcA       (SrcA),
    .SrcB       (SrcB),
    .FlagW      (FlagW),
    .CondEx     (CondEx),
    .ready      (ready),
    .valid_out  (valid_out),
    .Result     (Result),
    .Flags      (Flags),
    .FlagsNext  (FlagsNext),
    .pending    (pending)
  );

  // Reference state: architectural flags plus at most one in-flight operation.
  logic [3:0]  m_flags;
  logic        m_busy;
  logic [31:0] m_res;
  logic [3:0]  m_nzcv;
  logic        m_wr_nz;
  logic        m_wr_cv;

  task automatic model_clear();
    m_flags = 4'd0; m_busy = 1'b0; m_res = 32'd0;
    m_nzcv  = 4'd0; m_wr_nz = 1'b0; m_wr_cv = 1'b0;
  endtask

  task automatic model_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] r, output logic [3:0] f);
    longint unsigned ua, ub;
    longint          sa, sb, ss;
    logic            c, v;
    ua = longint'(a); ub = longint'(b);
    sa = longint'($signed(a)); sb = longint'($signed(b));
    c = 1'b0; v = 1'b0; ss = 0;
    case (op)
      2'd0: begin r = a + b; c = (ua + ub) > 64'hFFFF_FFFF; ss = sa + sb; end
      2'd1: begin r = a - b; c = (ua >= ub); ss = sa - sb; end
      2'd2: r = a & b;
      default: r = a | b;
    endcase
    if (op < 2'd2) v = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
    f = {r[31], r == 32'd0, c, v};
  endtask

  function automatic logic [3:0] model_next();
    logic [3:0] n;
    n = m_flags;
    if (m_busy && m_wr_nz) n[3:2] = m_nzcv[3:2];
    if (m_busy && m_wr_cv) n[1:0] = m_nzcv[1:0];
    return n;
  endfunction

  task automatic model_edge(input logic v, input logic h, input logic [1:0] op,
                            input logic [31:0] a, input logic [31:0] b,
                            input logic [1:0] fw, input logic ce);
    logic [31:0] r;
    logic [3:0]  f;
    if (h) return;
    m_flags = model_next();
    m_busy  = v;
    if (v) begin
      model_op(op, a, b, r, f);
      m_res   = r;
      m_nzcv  = f;
      m_wr_nz = fw[1] && ce;
      m_wr_cv = fw[0] && ce && (op < 2'd2);
    end
  endtask

  task automatic drive(input logic v, input logic h, input logic [1:0] op,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [1:0] fw, input logic ce);
    valid_in = v; hold = h; ALUControl = op; SrcA = a; SrcB = b; FlagW = fw; CondEx = ce;
    model_edge(v, h, op, a, b, fw, ce);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 2'd0, 32'd0, 32'd0, 2'd0, 1'b0);
  endtask

  task automatic test_reset();
    reset = 1'b1; valid_in = 1'b0; hold = 1'b0; ALUControl = 2'd0;
    SrcA = 32'd0; SrcB = 32'd0; FlagW = 2'd0; CondEx = 1'b0;
    model_clear();
    #2;
    checks++;
    if ({Flags, valid_out, Result, pending, FlagsNext} !== {4'd0, 1'b0, 32'd0, 1'b0, 4'd0}) begin
      errors++;
      $display("FAIL reset_init: flags=%b vo=%b res=%h pend=%b next=%b want all zero",
               Flags, valid_out, Result, pending, FlagsNext);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    // Stage a commit, then assert reset mid-cycle before it can land.
    drive(1'b1, 1'b0, 2'd0, 32'hFFFF_FFFF, 32'd5, 2'b11, 1'b1);
    #3 reset = 1'b1;
    #1;
    checks++;
    if ({Flags, valid_out, Result, pending, FlagsNext} !== {4'd0, 1'b0, 32'd0, 1'b0, 4'd0}) begin
      errors++;
      $display("FAIL reset_async: flags=%b vo=%b res=%h pend=%b next=%b want all zero",
               Flags, valid_out, Result, pending, FlagsNext);
    end
    #1 reset = 1'b0;
    model_clear();
    idle();
    idle();
    checks++;
    if (Flags !== 4'd0 || valid_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_discard: flags=%b vo=%b want 0000 0", Flags, valid_out);
    end
  endtask

  task automatic test_sub_zero();
    drive(1'b1, 1'b0, 2'd1, 32'd5, 32'd5, 2'b11, 1'b1);
    checks++;
    if ({Result, valid_out, pending, FlagsNext} !== {32'd0, 1'b1, 1'b1, 4'b0110}) begin
      errors++;
      $display("FAIL sub_zero_stage: res=%h vo=%b pend=%b next=%b want 0 1 1 0110",
               Result, valid_out, pending, FlagsNext);
    end
    idle();
    checks++;
    if (Flags !== 4'b0110 || valid_out !== 1'b0) begin
      errors++;
      $display("FAIL sub_zero_commit: flags=%b vo=%b want 0110 0", Flags, valid_out);
    end
  endtask

  task automatic test_add_overflow();
    drive(1'b1, 1'b0, 2'd0, 32'h7FFF_FFFF, 32'd1, 2'b11, 1'b1);
    checks++;
    if (Result !== 32'h8000_0000) begin
      errors++;
      $display("FAIL add_ovf_result: got %h want 80000000", Result);
    end
    idle();
    checks++;
    if (Flags !== 4'b1001) begin
      errors++;
      $display("FAIL add_ovf_flags: got %b want 1001", Flags);
    end
  endtask

  task automatic test_logic_preserve();
    drive(1'b1, 1'b0, 2'd2, 32'h0000_00F0, 32'h0000_000F, 2'b11, 1'b1);
    checks++;
    if (Result !== 32'd0 || FlagsNext !== 4'b0101) begin
      errors++;
      $display("FAIL and_stage: res=%h next=%b want 0 0101", Result, FlagsNext);
    end
    idle();
    checks++;
    if (Flags !== 4'b0101) begin
      errors++;
      $display("FAIL and_flags: got %b want 0101", Flags);
    end
  endtask

  task automatic test_cond_fail();
    drive(1'b1, 1'b0, 2'd1, 32'd3, 32'd5, 2'b11, 1'b0);
    checks++;
    if ({Result, valid_out, pending, FlagsNext} !== {32'hFFFF_FFFE, 1'b1, 1'b0, 4'b0101}) begin
      errors++;
      $display("FAIL condfail_stage: res=%h vo=%b pend=%b next=%b want fffffffe 1 0 0101",
               Result, valid_out, pending, FlagsNext);
    end
    idle();
    checks++;
    if (Flags !== 4'b0101 || Result !== 32'hFFFF_FFFE) begin
      errors++;
      $display("FAIL condfail_flags: flags=%b res=%h want 0101 fffffffe", Flags, Result);
    end
  endtask

  task automatic test_hold();
    drive(1'b1, 1'b0, 2'd0, 32'hFFFF_FFFF, 32'd1, 2'b11, 1'b1);
    for (int i = 0; i < 3; i++) begin
      // valid_in asserted during hold must be ignored.
      drive(1'b1, 1'b1, 2'd1, 32'd9, 32'd1, 2'b11, 1'b1);
      checks++;
      if (Flags !== 4'b0101 || pending !== 1'b1 || ready !== 1'b0 || Result !== 32'd0) begin
        errors++;
        $display("FAIL hold_%0d: flags=%b pend=%b ready=%b res=%h want 0101 1 0 0",
                 i, Flags, pending, ready, Result);
      end
    end
    idle();
    checks++;
    if (Flags !== 4'b0110 || ready !== 1'b1 || valid_out !== 1'b0) begin
      errors++;
      $display("FAIL hold_release: flags=%b ready=%b vo=%b want 0110 1 0", Flags, ready, valid_out);
    end
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 1'b0, 2'd0, 32'h7FFF_FFFF, 32'd1, 2'b11, 1'b1);
    drive(1'b1, 1'b0, 2'd1, 32'd5, 32'd5, 2'b01, 1'b1);
    checks++;
    if (Flags !== 4'b1001 || FlagsNext !== 4'b1010 || Result !== 32'd0) begin
      errors++;
      $display("FAIL b2b_first: flags=%b next=%b res=%h want 1001 1010 0", Flags, FlagsNext, Result);
    end
    idle();
    checks++;
    if (Flags !== 4'b1010) begin
      errors++;
      $display("FAIL b2b_second: flags=%b want 1010", Flags);
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    logic [3:0]  exp_next;
    logic        exp_pend;
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0: a = 32'h7FFF_FFFF;
        1: a = 32'h8000_0000;
        2: a = $urandom_range(0, 3);
        default: a = $urandom;
      endcase
      b = ($urandom_range(0, 3) == 0) ? a : (($urandom_range(0, 1) == 0) ? $urandom_range(0, 2) : $urandom);
      drive(($urandom_range(0, 9) < 7), ($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)),
            a, b, 2'($urandom_range(0, 3)), ($urandom_range(0, 4) != 0));
      exp_pend = m_busy && (m_wr_nz || m_wr_cv);
      exp_next = model_next();
      checks++;
      if ({valid_out, Result, Flags, pending, FlagsNext, ready} !==
          {m_busy, m_res, m_flags, exp_pend, exp_next, ~hold}) begin
        errors++;
        $display("FAIL random_%0d: vo=%b res=%h flags=%b pend=%b next=%b rdy=%b want %b %h %b %b %b %b",
                 i, valid_out, Result, Flags, pending, FlagsNext, ready,
                 m_busy, m_res, m_flags, exp_pend, exp_next, ~hold);
      end
    end
  endtask

  initial begin
    test_reset();
    test_sub_zero();
    test_add_overflow();
    test_logic_preserve();
    test_cond_fail();
    test_hold();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/flags_update.md
FLAGS_UPDATE -- requirements
Module: flags_update

Interface
REQ-001 SHALL have one clock and reset: reset is asynchronous and active-high.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 reset  input  1  async active-high reset.
REQ-004 valid_in  input  1  operation present on SrcA/SrcB/ALUControl/FlagW/CondEx this cycle.
REQ-005 hold  input  1  stall; freezes all internal registers.
REQ-006 ALUControl  input  2  00 ADD, 01 SUB, 10 AND, 11 ORR.
REQ-007 SrcA, SrcB  input  32 each  operands.
REQ-008 FlagW  input  2  bit1 = write N,Z; bit0 = write C,V.
REQ-009 CondEx  input  1  condition passed for this operation (from condition-check stage).
REQ-010 ready  output  1  equals ~hold.
REQ-011 valid_out  output  1  Result valid.
REQ-012 Result  output  32  registered ALU result.
REQ-013 Flags  output  4  architectural NZCV register (bit3 N, bit2 Z, bit1 C, bit0 V).
REQ-014 FlagsNext  output  4  combinational: staged NZCV merge when a commit is pending, else Flags.
REQ-015 pending  output  1  a flag commit is staged and not yet applied.

Function
REQ-016 Accept: operation captured on rising edge when valid_in & ~hold; valid_in ignored while hold=1.
REQ-017 Stage 1 (capture edge): Result, staged NZCV, staged write mask (FlagW & {2{CondEx}}) and valid_q SHALL register; valid_out = valid_q (latency 1 cycle).
REQ-018 Stage 2 (next edge, ~hold): if valid_q, Flags N,Z SHALL load staged N,Z when mask[1]; C,V SHALL load staged C,V when mask[0]; unmasked bits retain.
REQ-019 Flags update latency: 2 edges after acceptance; pending = valid_q & (mask != 0).
REQ-020 ADD: 33-bit sum A+B; Result = sum[31:0]; C = sum[32]; V = (A[31]==B[31]) & (Result[31]!=A[31]).
REQ-021 SUB: A + ~B + 1; C = carry out (1 = no borrow); V = (A[31]!=B[31]) & (Result[31]!=A[31]).
REQ-022 AND/ORR: bitwise; mask bit0 SHALL be forced 0 (C,V preserved).
REQ-023 All ops: N = Result[31]; Z = (Result == 0).
REQ-024 CondEx=0: Result and valid_out still produced; no flag bit SHALL change.
REQ-025 Back-to-back ops: op k+1 may be accepted the edge op k commits; commits apply strictly in order, one per edge.
REQ-026 FlagsNext SHALL equal Flags with masked staged bits substituted when pending, so a dependent condition check sees the value Flags will hold next edge.
REQ-027 hold=1: valid_q, Result, staged state and Flags SHALL not change; commit occurs on first edge with hold=0.
REQ-028 No valid_in at an edge (or hold released with valid_in=0): valid_q clears after its commit; Result retains last value.

Reset
REQ-029 reset=1 SHALL immediately force Flags=0000, Result=0, valid_q=0, staged NZCV=0, mask=00; hence valid_out=0, pending=0, FlagsNext=0000.
REQ-030 Reset mid-operation SHALL discard staged commit; no flag write occurs after reset release without a new accepted op.

Verification
REQ-031 Assert reset asynchronously mid-cycle -> Flags=0000, valid_out=0, Result=0 before next edge.
REQ-032 SUB 5-5, FlagW=11, CondEx=1 -> edge+1 Result=0, valid_out=1, pending=1, FlagsNext=0110; edge+2 Flags=0110.
REQ-033 ADD 0x7FFFFFFF+1, FlagW=11, CondEx=1 -> Result=0x80000000; Flags=1001.
REQ-034 With Flags=1001, AND 0xF0 & 0x0F, FlagW=11 -> Result=0; Flags=0101 (C,V preserved).
REQ-035 SUB 3-5, FlagW=11, CondEx=0 -> Result=0xFFFFFFFE, valid_out=1, pending=0, Flags unchanged.
REQ-036 ADD 0xFFFFFFFF+1 accepted, hold=1 for 3 cycles after capture -> Flags unchanged, pending=1 throughout; first edge after hold drops Flags=0110.
